// File: rtl/pattern_playback_pkg.sv
// Shared types and constants for the stored-pattern playback reader.
package pattern_playback_pkg;

  localparam int unsigned SLOT_W     = 16;
  localparam int unsigned NUM_SLOTS  = 4;
  localparam int unsigned SLOT_IDX_W = 2;
  localparam int unsigned BANK_W     = SLOT_W * NUM_SLOTS;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    PAUSE,
    DONE
  } state_t;

  // Selects slot idx from a 64-bit bank; slot 0 lives in the low 16 bits.
  function automatic logic [SLOT_W-1:0] slot_word(
    input logic [BANK_W-1:0]     bank,
    input logic [SLOT_IDX_W-1:0] idx
  );
    logic [SLOT_W-1:0] word;
    word = '0;
    case (idx)
      2'd0:    word = bank[15:0];
      2'd1:    word = bank[31:16];
      2'd2:    word = bank[47:32];
      default: word = bank[63:48];
    endcase
    return word;
  endfunction

endpackage

// File: rtl/pattern_playback_seq_btn_rise_detect.sv
// Single-bit rising-edge detector for an already debounced button.
module btn_rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  logic btn_q;

  // Button history register; cleared by reset so a held button after reset acts once.
  always_ff @(posedge clk) begin
    if (reset) btn_q <= 1'b0;
    else       btn_q <= btn;
  end

  // Rise is combinational so it takes effect at the very next clock edge.
  always_comb begin
    rise = btn & ~btn_q;
  end

endmodule

// File: rtl/pattern_playback_seq.sv
// Plays back a snapshot of the four-slot pattern bank at a fixed tick rate,
// with play/pause, single-step, stop and loop / one-shot control.
module pattern_playback_seq
  import pattern_playback_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BANK_W-1:0]     stored,
  input  logic                  play,
  input  logic                  stop,
  input  logic                  step,
  input  logic                  loop_en,
  output logic [SLOT_W-1:0]     pattern,
  output logic [SLOT_IDX_W-1:0] slot,
  output logic [3:0]            digit3,
  output logic [3:0]            digit2,
  output logic [3:0]            digit1,
  output logic [3:0]            digit0,
  output logic                  frame_valid,
  output logic                  busy
);

  localparam int unsigned              CNT_W     = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]         TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [SLOT_IDX_W-1:0]    SLOT_LAST = SLOT_IDX_W'(NUM_SLOTS - 1);

  state_t                  state, state_n;
  logic [BANK_W-1:0]       snapshot, snapshot_n;
  logic [CNT_W-1:0]        tick_cnt, tick_cnt_n;
  logic [SLOT_W-1:0]       pattern_n;
  logic [SLOT_IDX_W-1:0]   slot_n;
  logic                    frame_valid_n;
  logic                    advance;
  logic                    play_rise, stop_rise, step_rise;

  btn_rise_detect u_play_rise (.clk(clk), .reset(reset), .btn(play), .rise(play_rise));
  btn_rise_detect u_stop_rise (.clk(clk), .reset(reset), .btn(stop), .rise(stop_rise));
  btn_rise_detect u_step_rise (.clk(clk), .reset(reset), .btn(step), .rise(step_rise));

  // State, snapshot, tick counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      snapshot    <= '0;
      tick_cnt    <= '0;
      pattern     <= '0;
      slot        <= '0;
      frame_valid <= 1'b0;
    end else begin
      state       <= state_n;
      snapshot    <= snapshot_n;
      tick_cnt    <= tick_cnt_n;
      pattern     <= pattern_n;
      slot        <= slot_n;
      frame_valid <= frame_valid_n;
    end
  end

  // Next-state logic; event priority is stop > play > step > tick.
  // Tick and step share one advance path so wrap/done handling lives in one place.
  always_comb begin
    state_n       = state;
    snapshot_n    = snapshot;
    tick_cnt_n    = tick_cnt;
    pattern_n     = pattern;
    slot_n        = slot;
    frame_valid_n = 1'b0;
    advance       = 1'b0;

    if (stop_rise) begin
      state_n    = IDLE;
      tick_cnt_n = '0;
      pattern_n  = '0;
      slot_n     = '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (play_rise) begin
            state_n       = PLAY;
            snapshot_n    = stored;
            tick_cnt_n    = '0;
            slot_n        = '0;
            pattern_n     = stored[SLOT_W-1:0];
            frame_valid_n = 1'b1;
          end
        end
        PLAY: begin
          if (play_rise) begin
            state_n    = PAUSE;
            tick_cnt_n = '0;
          end else if (tick_cnt == TICK_LAST) begin
            tick_cnt_n = '0;
            advance    = 1'b1;
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
        PAUSE: begin
          if (play_rise) state_n = PLAY;
          else if (step_rise) advance = 1'b1;
        end
        default: state_n = IDLE;
      endcase

      if (advance) begin
        if (slot != SLOT_LAST) begin
          slot_n        = slot + 1'b1;
          pattern_n     = slot_word(snapshot, slot_n);
          frame_valid_n = 1'b1;
        end else if (loop_en) begin
          slot_n        = '0;
          pattern_n     = slot_word(snapshot, '0);
          frame_valid_n = 1'b1;
        end else begin
          state_n = DONE;
        end
      end
    end
  end

  // Status and seven-segment nibbles derived from registered state.
  always_comb begin
    busy   = (state == PLAY) || (state == PAUSE);
    digit3 = pattern[15:12];
    digit2 = pattern[11:8];
    digit1 = pattern[7:4];
    digit0 = pattern[3:0];
  end

endmodule
